// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM state encoding and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    // Odd parity holds when data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches kclk over FILTER_LEN samples and flags its falling edges.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kclk,
    input  logic kdata,
    output logic fall,
    output logic data
);

    localparam int CNT_W = $clog2(FILTER_LEN);

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic [CNT_W-1:0] cnt;
    logic             filt;
    logic             filt_prev;

    // The filtered clock only follows the synchronised line after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            cnt       <= '0;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], kclk};
            data_sync <= {data_sync[0], kdata};
            filt_prev <= filt;
            if (clk_sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                filt <= clk_sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt;
    assign data = data_sync[1];

endmodule

// File: rtl/ps2_rx_fsm.sv
// PS/2 frame receiver: start/data/parity/stop sequencing with valid and error strobes.
// Optional inter-edge timeout is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_rx_fsm
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_US  = 2000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic [7:0] scan_code_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       busy_o
);

    if (FILTER_LEN < 2 || CLK_FREQ_HZ < 1_000_000 || TIMEOUT_US < 1) begin : g_bad_params
        $error("ps2_rx_fsm: unsupported parameter values");
    end

    logic                     fall;
    logic                     data;
    ps2_state_t               state;
    logic [PS2_DATA_BITS-1:0] shift;
    logic [2:0]               bit_cnt;
    logic                     par_ok;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_line_filter (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .kclk  (kclk_i),
        .kdata (kdata_i),
        .fall  (fall),
        .data  (data)
    );

    // Every state advance happens on a filtered falling edge; the timeout only acts between edges.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            par_ok      <= 1'b0;
            scan_code_o <= 8'h00;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (fall) begin
`ifdef PS2_RX_TIMEOUT_EN
                to_cnt <= '0;
`endif
                case (state)
                    IDLE: begin
                        if (!data) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                            busy_o  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift   <= {data, shift[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok <= odd_parity_ok(shift, data);
                        state  <= STOP;
                    end
                    STOP: begin
                        if (data && par_ok) begin
                            scan_code_o <= shift;
                            valid_o     <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef PS2_RX_TIMEOUT_EN
            else if (state != IDLE) begin
                if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    err_o  <= 1'b1;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_rx_fsm.sv
// Self-checking bench for ps2_rx_fsm: directed PS/2 frames plus randomized good/bad frames against a frame-level model.
`timescale 1ns/1ps
module tb_ps2_rx_fsm;

    localparam int FILTER_LEN     = 8;
    localparam int CLK_FREQ_HZ    = 10_000_000;
    localparam int TIMEOUT_US     = 100;
    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int HALF           = 20;
    localparam int TAIL           = 30;

    logic       clk = 1'b0;
    logic       rstn;
    logic       kclk;
    logic       kdata;
    logic [7:0] scan_code;
    logic       valid;
    logic       err;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] code_q[$];
    logic [7:0] exp_code;

    ps2_rx_fsm #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_US  (TIMEOUT_US)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .kclk_i      (kclk),
        .kdata_i     (kdata),
        .scan_code_o (scan_code),
        .valid_o     (valid),
        .err_o       (err),
        .busy_o      (busy)
    );

    always #50 clk = ~clk;

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid) begin
                valid_cnt++;
                code_q.push_back(scan_code);
            end
            if (err) err_cnt++;
            if (valid && err) both_cnt++;
        end
    end

    // Frame-level reference: a frame is accepted when the stop bit is 1 and data+parity hold an odd count of ones.
    function automatic logic frame_good(input logic [7:0] d, input logic p, input logic s);
        return s && ((($countones(d) + int'(p)) % 2) == 1);
    endfunction

    function automatic logic good_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        kdata = b;
        wait_cycles(HALF);
        kclk = 1'b0;
        wait_cycles(HALF);
        kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        kdata = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        kclk = 1'b1;
        kdata = 1'b1;
        wait_cycles(5);
        checks++; if (scan_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_scan got %h expected 00", scan_code); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        rstn = 1'b1;
        wait_cycles(40);
        checks++; if (valid_cnt + err_cnt !== 0) begin errors++; $display("[TB] FAIL reset_exit_pulses got %0d expected 0", valid_cnt + err_cnt); end
        exp_code = 8'h00;
    endtask

    task automatic test_good_frame();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        code_q.delete();
        send_frame(8'h1C, good_parity(8'h1C), 1'b1);
        wait_cycles(TAIL);
        exp_code = 8'h1C;
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("[TB] FAIL good_valid_count got %0d expected 1", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL good_err_count got %0d expected 0", err_cnt - e0); end
        checks++; if (scan_code !== exp_code) begin errors++; $display("[TB] FAIL good_scan got %h expected %h", scan_code, exp_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL good_busy_after got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        code_q.delete();
        send_frame(8'hF0, good_parity(8'hF0), 1'b1);
        send_frame(8'h1C, good_parity(8'h1C), 1'b1);
        wait_cycles(TAIL);
        exp_code = 8'h1C;
        checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("[TB] FAIL b2b_valid_count got %0d expected 2", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL b2b_err_count got %0d expected 0", err_cnt - e0); end
        checks++;
        if (code_q.size() !== 2) begin
            errors++; $display("[TB] FAIL b2b_codes got %0d codes expected 2", code_q.size());
        end else if (code_q[0] !== 8'hF0 || code_q[1] !== 8'h1C) begin
            errors++; $display("[TB] FAIL b2b_codes got %h,%h expected f0,1c", code_q[0], code_q[1]);
        end
        checks++; if (scan_code !== exp_code) begin errors++; $display("[TB] FAIL b2b_scan got %h expected %h", scan_code, exp_code); end
    endtask

    task automatic test_parity_error();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        wait_cycles(TAIL);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL parity_err_count got %0d expected 1", err_cnt - e0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL parity_valid_count got %0d expected 0", valid_cnt - v0); end
        checks++; if (scan_code !== exp_code) begin errors++; $display("[TB] FAIL parity_scan_kept got %h expected %h", scan_code, exp_code); end
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        int busy_seen = 0;
        kclk = 1'b0;
        wait_cycles(FILTER_LEN - 1);
        kclk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("[TB] FAIL glitch_busy got %0d busy cycles expected 0", busy_seen); end
        checks++; if (valid_cnt + err_cnt - v0 - e0 !== 0) begin errors++; $display("[TB] FAIL glitch_pulses got %0d expected 0", valid_cnt + err_cnt - v0 - e0); end
        send_frame(8'h5A, good_parity(8'h5A), 1'b1);
        wait_cycles(TAIL);
        exp_code = 8'h5A;
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("[TB] FAIL glitch_next_valid got %0d expected 1", valid_cnt - v0); end
        checks++; if (scan_code !== exp_code) begin errors++; $display("[TB] FAIL glitch_next_scan got %h expected %h", scan_code, exp_code); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        int e0;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        wait_cycles(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before got %b expected 1", busy); end
        rstn = 1'b0;
        kdata = 1'b1;
        wait_cycles(3);
        checks++; if (scan_code !== 8'h00) begin errors++; $display("[TB] FAIL midreset_scan got %h expected 00", scan_code); end
        checks++; if (valid !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulses got %b%b expected 00", valid, err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b expected 0", busy); end
        rstn = 1'b1;
        exp_code = 8'h00;
        wait_cycles(40);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h29, good_parity(8'h29), 1'b1);
        wait_cycles(TAIL);
        exp_code = 8'h29;
        checks++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL midreset_next got valid %0d err %0d expected 1 0", valid_cnt - v0, err_cnt - e0); end
        checks++; if (scan_code !== exp_code) begin errors++; $display("[TB] FAIL midreset_next_scan got %h expected %h", scan_code, exp_code); end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 12; n++) begin
            int v0 = valid_cnt;
            int e0 = err_cnt;
            int kind = int'($urandom_range(0, 2));
            logic [7:0] d = 8'($urandom);
            logic p = good_parity(d) ^ (kind == 1);
            logic s = (kind != 2);
            logic ok = frame_good(d, p, s);
            send_frame(d, p, s);
            wait_cycles(TAIL);
            if (ok) exp_code = d;
            checks++; if (valid_cnt - v0 !== int'(ok)) begin errors++; $display("[TB] FAIL rand%0d_valid got %0d expected %0d (data %h kind %0d)", n, valid_cnt - v0, int'(ok), d, kind); end
            checks++; if (err_cnt - e0 !== int'(!ok)) begin errors++; $display("[TB] FAIL rand%0d_err got %0d expected %0d (data %h kind %0d)", n, err_cnt - e0, int'(!ok), d, kind); end
            checks++; if (scan_code !== exp_code) begin errors++; $display("[TB] FAIL rand%0d_scan got %h expected %h", n, scan_code, exp_code); end
        end
    endtask

    task automatic test_timeout();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        kdata = 1'b1;
`ifdef PS2_RX_TIMEOUT_EN
        begin
            int n = 0;
            logic seen = 1'b0;
            while (!seen && n < TIMEOUT_CYCLES + 200) begin
                @(negedge clk);
                n++;
                if (err) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++; $display("[TB] FAIL timeout_seen got none expected err within %0d cycles", TIMEOUT_CYCLES + 200);
            end else if (n + HALF < TIMEOUT_CYCLES || n + HALF > TIMEOUT_CYCLES + 40) begin
                errors++; $display("[TB] FAIL timeout_delay got %0d expected %0d..%0d", n + HALF, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 40);
            end
            wait_cycles(200);
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy got %b expected 0", busy); end
            checks++; if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL timeout_pulses got err %0d valid %0d expected 1 0", err_cnt - e0, valid_cnt - v0); end
        end
`else
        wait_cycles(TIMEOUT_CYCLES + 200);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy got %b expected 1", busy); end
        checks++; if (err_cnt - e0 !== 0 || valid_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL stall_pulses got err %0d valid %0d expected 0 0", err_cnt - e0, valid_cnt - v0); end
        rstn = 1'b0;
        wait_cycles(3);
        rstn = 1'b1;
        exp_code = 8'h00;
        wait_cycles(40);
`endif
        v0 = valid_cnt;
        send_frame(8'h1C, good_parity(8'h1C), 1'b1);
        wait_cycles(TAIL);
        exp_code = 8'h1C;
        checks++; if (valid_cnt - v0 !== 1 || scan_code !== exp_code) begin errors++; $display("[TB] FAIL timeout_recover got valid %0d scan %h expected 1 %h", valid_cnt - v0, scan_code, exp_code); end
    endtask

    initial begin
        rstn = 1'b0;
        kclk = 1'b1;
        kdata = 1'b1;
        $display("[TB] starting ps2_rx_fsm bench");
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_parity_error();
        test_glitch();
        test_reset_mid_frame();
        test_random_frames();
        test_timeout();
        checks++; if (both_cnt !== 0) begin errors++; $display("[TB] FAIL valid_err_overlap got %0d expected 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
